// File: rtl/bc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IF and LSU.
// Grants are held until accepted; read responses are routed in order via a tag FIFO.
module bc_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_valid,
  output logic [1:0]              o_req_ready,
  input  logic [1:0]              i_req_we,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  output logic [1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rsp_rdata,
  output logic                    o_unexp_rsp
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic                       last_grant;
  logic                       lock_valid;
  logic                       lock_sel;
  logic [MAX_OUTSTANDING-1:0] tags;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  logic sel;
  logic sel_valid;
  logic sel_read;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic push;
  logic pop;

  // Pick the requester: a held grant wins, otherwise round-robin on contest.
  always_comb begin
    sel = 1'b0;
    if (lock_valid) begin
      sel = lock_sel;
    end else begin
      case (i_req_valid)
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~last_grant;
        default: sel = 1'b0;
      endcase
    end
  end

  assign sel_valid  = i_req_valid[sel];
  assign sel_read   = ~i_req_we[sel];
  assign fifo_full  = (count == CNT_MAX);
  assign fifo_empty = (count == '0);

  assign o_mem_req_valid = ~i_rst & sel_valid & ~(sel_read & fifo_full);
  assign o_mem_we        = i_req_we[sel];
  assign o_mem_addr      = sel ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : i_req_addr[ADDR_WIDTH-1:0];
  assign o_mem_wdata     = sel ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : i_req_wdata[DATA_WIDTH-1:0];

  assign accept      = o_mem_req_valid & i_mem_req_ready;
  assign o_req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign push = accept & sel_read;
  assign pop  = ~i_rst & i_mem_rsp_valid & ~fifo_empty;

  assign o_rsp_valid = pop ? (tags[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_rdata = i_mem_rsp_rdata;
  assign o_unexp_rsp = ~i_rst & i_mem_rsp_valid & fifo_empty;

  // Round-robin history and grant lock; a stalled selection stays locked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= 1'b1;
      lock_valid <= 1'b0;
      lock_sel   <= 1'b0;
    end else if (accept) begin
      last_grant <= sel;
      lock_valid <= 1'b0;
    end else if (sel_valid) begin
      lock_valid <= 1'b1;
      lock_sel   <= sel;
    end
  end

  // Tag storage for outstanding reads; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tags[wr_ptr] <= sel;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bc_mem_arbiter.sv
// Self-checking bench for bc_mem_arbiter.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_bc_mem_arbiter;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        unexp;

  int tests;
  int fails;

  bc_mem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_we(req_we),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_mem_req_valid(mem_req_valid),
    .i_mem_req_ready(mem_ready),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rsp_valid(rsp_v),
    .i_mem_rsp_rdata(rsp_d),
    .o_unexp_rsp(unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    rsp_v     = 1'b0;
    rsp_d     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    mem_ready = 1'b1;
    rsp_v = 1'b1;
    #1;
    tests++;
    if ({req_ready, mem_req_valid, rsp_valid, unexp} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000",
               {req_ready, mem_req_valid, rsp_valid, unexp});
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_read();
    req_valid = 2'b01;
    req_addr[31:0] = 32'h100;
    mem_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b01 || mem_addr !== 32'h100 ||
        mem_we !== 1'b0 || mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_issue: rdy=%b addr=%h we=%b v=%b want 01 100 0 1",
               req_ready, mem_addr, mem_we, mem_req_valid);
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    rsp_v = 1'b1;
    rsp_d = 32'hDEADBEEF;
    #1;
    tests++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || unexp !== 1'b0) begin
      fails++;
      $display("FAIL single_rsp: v=%b d=%h ux=%b want 01 deadbeef 0",
               rsp_valid, rsp_rdata, unexp);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_alternate();
    logic [1:0]  eg;
    logic [31:0] ea;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      req_we = 2'b00;
      req_addr = {32'h2000 + 32'(i), 32'h1000 + 32'(i)};
      mem_ready = 1'b1;
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      ea = (i % 2 == 1) ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i);
      #1;
      tests++;
      if (req_ready !== eg || mem_addr !== ea) begin
        fails++;
        $display("FAIL alt_grant%0d: rdy=%b addr=%h want %b %h",
                 i, req_ready, mem_addr, eg, ea);
      end
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rsp_v = 1'b1;
      rsp_d = 32'hA000 + 32'(i);
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      tests++;
      if (rsp_valid !== eg || rsp_rdata !== 32'hA000 + 32'(i)) begin
        fails++;
        $display("FAIL alt_rsp%0d: v=%b d=%h want %b %h",
                 i, rsp_valid, rsp_rdata, eg, 32'hA000 + 32'(i));
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_write_hold();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 2'b10 : 2'b11;
      req_we = 2'b10;
      req_addr = {32'h40, 32'h300};
      req_wdata = {32'h5A, 32'h0};
      mem_ready = (c == 3);
      #1;
      tests++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b1 ||
          mem_wdata !== 32'h5A || req_ready !== ((c == 3) ? 2'b10 : 2'b00)) begin
        fails++;
        $display("FAIL hold_c%0d: v=%b a=%h we=%b wd=%h rdy=%b want 1 40 1 5a %b",
                 c, mem_req_valid, mem_addr, mem_we, mem_wdata, req_ready,
                 (c == 3) ? 2'b10 : 2'b00);
      end
      @(negedge clk);
    end
    req_valid = 2'b01;
    req_we = 2'b00;
    mem_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b01 || mem_addr !== 32'h300) begin
      fails++;
      $display("FAIL hold_after: rdy=%b a=%h want 01 300", req_ready, mem_addr);
    end
    @(negedge clk);
    idle();
    rsp_v = 1'b1;
    rsp_d = 32'h11;
    #1;
    tests++;
    if (rsp_valid !== 2'b01 || unexp !== 1'b0) begin
      fails++;
      $display("FAIL hold_rsp: v=%b ux=%b want 01 0", rsp_valid, unexp);
    end
    @(negedge clk);
    rsp_v = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 2'b00 || unexp !== 1'b1) begin
      fails++;
      $display("FAIL hold_notag: v=%b ux=%b want 00 1", rsp_valid, unexp);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      req_valid = 2'b01;
      req_addr[31:0] = 32'h500 + 32'(i);
      mem_ready = 1'b1;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
        fails++;
        $display("FAIL full_fill%0d: rdy=%b want 01", i, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 2'b10;
    req_we = 2'b10;
    req_addr = {32'h600, 32'h504};
    req_wdata = {32'h77, 32'h0};
    #1;
    tests++;
    if (req_ready !== 2'b10 || mem_we !== 1'b1 || mem_wdata !== 32'h77) begin
      fails++;
      $display("FAIL full_write: rdy=%b we=%b wd=%h want 10 1 77",
               req_ready, mem_we, mem_wdata);
    end
    @(negedge clk);
    req_valid = 2'b01;
    req_we = 2'b00;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
      fails++;
      $display("FAIL full_block: v=%b rdy=%b want 0 00", mem_req_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 2'b11;
    req_we = 2'b10;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
      fails++;
      $display("FAIL full_lock: v=%b rdy=%b want 0 00", mem_req_valid, req_ready);
    end
    @(negedge clk);
    rsp_v = 1'b1;
    rsp_d = 32'hB0;
    #1;
    tests++;
    if (rsp_valid !== 2'b01 || mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_samepop: rv=%b v=%b want 01 0", rsp_valid, mem_req_valid);
    end
    @(negedge clk);
    rsp_v = 1'b0;
    #1;
    tests++;
    if (req_ready !== 2'b01 || mem_addr !== 32'h504 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL full_unblock: rdy=%b a=%h we=%b want 01 504 0",
               req_ready, mem_addr, mem_we);
    end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL full_wr2: rdy=%b want 10", req_ready);
    end
    @(negedge clk);
    idle();
    for (int i = 0; i < MAXO; i++) begin
      rsp_v = 1'b1;
      #1;
      tests++;
      if (rsp_valid !== 2'b01 || unexp !== 1'b0) begin
        fails++;
        $display("FAIL full_drain%0d: v=%b ux=%b want 01 0", i, rsp_valid, unexp);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_unexp();
    rsp_v = 1'b1;
    rsp_d = 32'h1234;
    #1;
    tests++;
    if (unexp !== 1'b1 || rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL unexp: ux=%b v=%b want 1 00", unexp, rsp_valid);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (unexp !== 1'b0) begin
      fails++;
      $display("FAIL unexp_clear: ux=%b want 0", unexp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b10;
    mem_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL rmid_rd1: rdy=%b want 10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rmid_rd0: rdy=%b want 01", req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_v = 1'b1;
    #1;
    tests++;
    if ({req_ready, mem_req_valid, rsp_valid, unexp} !== 6'b0) begin
      fails++;
      $display("FAIL rmid_rst: got %b want 000000",
               {req_ready, mem_req_valid, rsp_valid, unexp});
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      rsp_v = 1'b1;
      #1;
      tests++;
      if (unexp !== 1'b1 || rsp_valid !== 2'b00) begin
        fails++;
        $display("FAIL rmid_unexp%0d: ux=%b v=%b want 1 00", i, unexp, rsp_valid);
      end
      @(negedge clk);
    end
    idle();
    req_valid = 2'b11;
    mem_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rmid_grant: rdy=%b want 01", req_ready);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    int          lg;
    int          hold;
    int          q[$];
    logic [1:0]  pend;
    int          s;
    logic        sv;
    logic        rd;
    logic        acc;
    logic [1:0]  e_rr;
    logic        e_mv;
    logic [1:0]  e_rv;
    logic        e_ux;
    logic [31:0] e_ad;
    logic [31:0] e_wd;
    logic        e_we;
    logic        bad;
    do_reset();
    lg = 1;
    hold = -1;
    q.delete();
    pend = 2'b00;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          req_we[r] = $urandom_range(0, 2) == 0;
          req_addr[r*32 +: 32] = $urandom;
          req_wdata[r*32 +: 32] = $urandom;
        end
      end
      req_valid = pend;
      mem_ready = $urandom_range(0, 3) != 0;
      rsp_v = ($urandom_range(0, 9) == 0) ||
              (q.size() > 0 && $urandom_range(0, 2) == 0);
      rsp_d = $urandom;
      rst = $urandom_range(0, 99) == 0;
      #1;
      if (hold >= 0) s = hold;
      else if (req_valid == 2'b10) s = 1;
      else if (req_valid == 2'b11) s = 1 - lg;
      else s = 0;
      sv = req_valid[s];
      rd = !req_we[s];
      e_mv = !rst && sv && !(rd && q.size() == MAXO);
      acc = e_mv && mem_ready;
      e_rr = acc ? (s == 1 ? 2'b10 : 2'b01) : 2'b00;
      e_we = req_we[s];
      e_ad = req_addr[s*32 +: 32];
      e_wd = req_wdata[s*32 +: 32];
      e_rv = 2'b00;
      if (!rst && rsp_v && q.size() > 0) e_rv = (q[0] == 1) ? 2'b10 : 2'b01;
      e_ux = !rst && rsp_v && q.size() == 0;
      bad = {req_ready, mem_req_valid, rsp_valid, unexp} !== {e_rr, e_mv, e_rv, e_ux};
      if (e_mv && {mem_we, mem_addr, mem_wdata} !== {e_we, e_ad, e_wd}) bad = 1'b1;
      if (e_rv != 2'b00 && rsp_rdata !== rsp_d) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL rand_c%0d: rr=%b mv=%b rv=%b ux=%b a=%h want %b %b %b %b %h",
                 c, req_ready, mem_req_valid, rsp_valid, unexp, mem_addr,
                 e_rr, e_mv, e_rv, e_ux, e_ad);
      end
      if (rst) begin
        q.delete();
        lg = 1;
        hold = -1;
      end else begin
        if (e_rv != 2'b00) void'(q.pop_front());
        if (acc) begin
          lg = s;
          hold = -1;
          if (rd) q.push_back(s);
        end else if (sv) begin
          hold = s;
        end
      end
      pend = pend & ~e_rr;
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_alternate();
    test_write_hold();
    test_fifo_full();
    test_unexp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
